input_divider_prog: RTL



---
 rtl/input_divider_prog.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/input_divider_prog.sv
// input_divider_prog
//   Programmable integer clock divider with near-50% duty, a ratio change
//   that only takes effect at a period boundary, graceful stop, clock
//   bypass and a windowed edge counter for frequency measurement.
//
//   Optional build macro: DIV_SYNC_OUT_EN
//     When defined, adds output sync_pulse: a one-cycle strobe on the last
//     cycle of every divided period (RUN or STOP only), used to align the
//     ADC timing generator. When undefined the port and its logic are absent.
//
//   Handshake note: meas_valid is a pure one-cycle strobe with no ready;
//   meas_count is stable from the cycle meas_valid is high until the next
//   strobe, so a consumer may capture it on the strobe or any time after.
//
//   Debug: state_dbg exposes the divider FSM state (0=IDLE, 1=RUN, 2=STOP).
module input_divider_prog #(
  parameter int DIV_W      = 4,
  parameter int MEAS_WIN   = 64,
  parameter int MEAS_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  en,
  input  logic [DIV_W-1:0]      ndiv,
  input  logic                  bypass_div,
  input  logic                  en_meas,
  output logic                  out,
  output logic                  out_meas,
  output logic [MEAS_CNT_W-1:0] meas_count,
  output logic                  meas_valid,
`ifdef DIV_SYNC_OUT_EN
  output logic                  sync_pulse,
`endif
  output logic [1:0]            state_dbg
);

  localparam int WIN_W = $clog2(MEAS_WIN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(MEAS_WIN - 1);
  localparam logic [DIV_W-1:0] N_MIN    = DIV_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // FSM and divider datapath
  state_e                  state_q, state_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic [DIV_W-1:0]        nsh_q, nsh_d;
  logic                    out_q, out_d;
  logic                    bypass_q, bypass_d;

  // measurement
  logic                    out_prev_q, out_prev_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic [MEAS_CNT_W-1:0]   edge_q, edge_d;
  logic [MEAS_CNT_W-1:0]   meas_count_q, meas_count_d;
  logic                    meas_valid_q, meas_valid_d;
  logic                    out_meas_q, out_meas_d;

  // period timing helpers
  logic [DIV_W-1:0]        ndiv_clamped;
  logic                    period_end;
  logic [DIV_W-1:0]        cnt_wrap;
  logic [DIV_W:0]          high_time;
  logic                    out_run;

  // measurement helpers
  logic                    edge_now;
  logic [MEAS_CNT_W-1:0]   edge_sum;

  // Bypass request is qualified by en so a disabled divider never passes clk.
  assign bypass_d = bypass_div & en;

  // Period timing: clamp the ratio, detect period end and compute next output level.
  always_comb begin
    ndiv_clamped = (ndiv < N_MIN) ? N_MIN : ndiv;
    period_end   = (cnt_q == (nsh_q - DIV_W'(1)));
    cnt_wrap     = period_end ? '0 : (cnt_q + DIV_W'(1));
    // High time is ceil(N/2); one extra bit keeps N = 2^DIV_W-1 exact.
    high_time    = ({1'b0, nsh_q} + (DIV_W + 1)'(1)) >> 1;
    // At a wrap cnt_wrap is 0, which is high for any ratio, so the new
    // ratio's high time is not needed on that edge.
    out_run      = ({1'b0, cnt_wrap} < high_time);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: bypass overrides everything and parks the FSM in IDLE.
  always_comb begin
    state_d = state_q;
    if (bypass_d) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (en) state_d = ST_RUN;
        ST_RUN:  if (!en) state_d = ST_STOP;
        ST_STOP: begin
          if (en) begin
            state_d = ST_RUN;
          end else if (period_end) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: counter, divided level and ratio shadow for the next edge.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    nsh_d = nsh_q;
    if (bypass_d) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (en) begin
            out_d = 1'b1;
            nsh_d = ndiv_clamped;
          end else begin
            out_d = 1'b0;
          end
        end
        ST_RUN, ST_STOP: begin
          if ((state_q == ST_STOP) && !en && period_end) begin
            // Stop only at the end of a full period so no runt pulse appears.
            cnt_d = '0;
            out_d = 1'b0;
          end else begin
            cnt_d = cnt_wrap;
            out_d = out_run;
          end
          // A new ratio is only picked up at a period boundary.
          if (period_end) begin
            nsh_d = ndiv_clamped;
          end
        end
        default: begin
          cnt_d = '0;
          out_d = 1'b0;
        end
      endcase
    end
  end

  // Divider datapath registers.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt_q    <= '0;
      nsh_q    <= N_MIN;
      out_q    <= 1'b0;
      bypass_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      nsh_q    <= nsh_d;
      out_q    <= out_d;
      bypass_q <= bypass_d;
    end
  end

  // Measurement next state: window counter, saturating edge counter, result.
  always_comb begin
    out_prev_d   = out_q;
    // Edges of the raw clock in bypass are not representative; ignore them.
    edge_now     = out_q & ~out_prev_q & ~bypass_q;
    edge_sum     = (edge_now && (edge_q != '1)) ? (edge_q + MEAS_CNT_W'(1)) : edge_q;
    win_d        = win_q;
    edge_d       = edge_q;
    meas_count_d = meas_count_q;
    meas_valid_d = 1'b0;
    out_meas_d   = out_meas_q;
    if (!en_meas) begin
      win_d      = '0;
      edge_d     = '0;
      out_meas_d = 1'b0;
    end else begin
      out_meas_d = out_meas_q ^ edge_now;
      if (win_q == WIN_LAST) begin
        // The closing cycle's own edge belongs to the closing window.
        meas_count_d = edge_sum;
        meas_valid_d = 1'b1;
        win_d        = '0;
        edge_d       = '0;
      end else begin
        win_d  = win_q + WIN_W'(1);
        edge_d = edge_sum;
      end
    end
  end

  // Measurement registers.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      out_prev_q   <= 1'b0;
      win_q        <= '0;
      edge_q       <= '0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
      out_meas_q   <= 1'b0;
    end else begin
      out_prev_q   <= out_prev_d;
      win_q        <= win_d;
      edge_q       <= edge_d;
      meas_count_q <= meas_count_d;
      meas_valid_q <= meas_valid_d;
      out_meas_q   <= out_meas_d;
    end
  end

  // In bypass the divided level is already forced low, so OR-ing the gated
  // clock in is glitch-free; rstb gates everything low while in reset.
  assign out        = rstb & ((clk & bypass_q) | out_q);
  assign out_meas   = out_meas_q;
  assign meas_count = meas_count_q;
  assign meas_valid = meas_valid_q;
  assign state_dbg  = state_q;

`ifdef DIV_SYNC_OUT_EN
  // Alignment strobe on the last cycle of each divided period.
  assign sync_pulse = rstb & ~bypass_q & period_end &
                      ((state_q == ST_RUN) || (state_q == ST_STOP));
`endif

endmodule
